// File: rtl/snes_pad_responder.sv
// snes_pad_responder
// -------------------------------------------------------------------------
// Device-side end of the SNES pad serial link: behaves like one SNES
// controller. The host drives latch/clock, and this block shifts out a
// button word on the active-low data line. Everything runs on posedge phi.
// The host pins are asynchronous to phi, so they are synchronised here.
//
// Ports:
//   phi            - system (CPU) clock
//   reset          - synchronous, active-high reset
//   buttons        - live button state, 1 = pressed (bit0 = B ... 12..15 = ID)
//   snes_latch_in  - host latch, active-high, asynchronous to phi
//   snes_clock_in  - host clock, idles high, shift on rising edge
//   snes_data      - serial data to host, active-low (0 = pressed)
//   frame_tick     - one-cycle pulse when a latch falling edge is seen
//   captured       - button word frozen at the last latch falling edge
//   bit_count      - bits shifted since the last latch
//   host_active    - a latch rise has been seen within TIMEOUT_CYCLES
// -------------------------------------------------------------------------
module snes_pad_responder #(
  parameter int   NUM_BITS       = 16,
  parameter logic FILL_BIT       = 1'b0,
  parameter int   TIMEOUT_CYCLES = 1818182
) (
  input  logic                       phi,
  input  logic                       reset,
  input  logic [NUM_BITS-1:0]        buttons,
  input  logic                       snes_latch_in,
  input  logic                       snes_clock_in,
  output logic                       snes_data,
  output logic                       frame_tick,
  output logic [NUM_BITS-1:0]        captured,
  output logic [$clog2(NUM_BITS):0]  bit_count,
  output logic                       host_active
);

  localparam int CNT_W = $clog2(NUM_BITS) + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_BITS);
  localparam logic [WD_W-1:0]  WD_MAX     = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_DROP    = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          latch_sync_q, latch_sync_d;
  logic [2:0]          clock_sync_q, clock_sync_d;
  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [NUM_BITS-1:0] captured_q, captured_d;
  logic [CNT_W-1:0]    bit_count_q, bit_count_d;
  logic [WD_W-1:0]     wd_count_q, wd_count_d;
  logic                snes_data_q, snes_data_d;
  logic                frame_tick_q, frame_tick_d;
  logic                host_active_q, host_active_d;

  logic latch_rise;
  logic latch_fall;
  logic clock_rise;

  // Two synchroniser stages plus one history stage per host pin; bit 0 is
  // the first stage. Edges compare stage 2 against the history stage.
  always_comb begin
    latch_sync_d = {latch_sync_q[1:0], snes_latch_in};
    clock_sync_d = {clock_sync_q[1:0], snes_clock_in};
    latch_rise   =  latch_sync_q[1] & ~latch_sync_q[2];
    latch_fall   = ~latch_sync_q[1] &  latch_sync_q[2];
    clock_rise   =  clock_sync_q[1] & ~clock_sync_q[2];
  end

  // Frame sequencer. A latch rise always wins over a coincident clock rise,
  // and in LOAD the clock is ignored, so a clock rise that coincides with
  // the latch fall never shifts away bit 0.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    captured_d   = captured_q;
    bit_count_d  = bit_count_q;
    frame_tick_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (latch_rise) begin
          state_d     = ST_LOAD;
          sr_d        = ~buttons;
          bit_count_d = '0;
        end
      end
      ST_LOAD: begin
        // Transparent parallel load while latch is high; the value loaded
        // in the fall cycle is the one that gets shifted out.
        sr_d        = ~buttons;
        bit_count_d = '0;
        if (latch_fall) begin
          state_d      = ST_SHIFT;
          captured_d   = buttons;
          frame_tick_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (latch_rise) begin
          state_d     = ST_LOAD;
          sr_d        = ~buttons;
          bit_count_d = '0;
        end else if (clock_rise) begin
          sr_d        = {1'b1, sr_q[NUM_BITS-1:1]};
          bit_count_d = bit_count_q + CNT_W'(1);
          if (bit_count_d == FULL_COUNT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (latch_rise) begin
          state_d     = ST_LOAD;
          sr_d        = ~buttons;
          bit_count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Data line is registered from the next-state view so it changes in
    // the same cycle as the state it belongs to.
    case (state_d)
      ST_IDLE: snes_data_d = 1'b1;
      ST_DONE: snes_data_d = FILL_BIT;
      default: snes_data_d = sr_d[0];
    endcase
  end

  // Host watchdog: every latch rise re-arms it; otherwise it counts up to
  // a saturating ceiling and drops host_active one cycle before the top.
  always_comb begin
    wd_count_d    = wd_count_q;
    host_active_d = host_active_q;
    if (latch_rise) begin
      wd_count_d    = '0;
      host_active_d = 1'b1;
    end else begin
      if (wd_count_q != WD_MAX) begin
        wd_count_d = wd_count_q + WD_W'(1);
      end
      if (wd_count_q == WD_DROP) begin
        host_active_d = 1'b0;
      end
    end
  end

  // All state lives here. Sync flops clear to 0, so a latch held high
  // across reset release is seen as a fresh rise.
  always_ff @(posedge phi) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      latch_sync_q  <= '0;
      clock_sync_q  <= '0;
      sr_q          <= '1;
      captured_q    <= '0;
      bit_count_q   <= '0;
      wd_count_q    <= '0;
      snes_data_q   <= 1'b1;
      frame_tick_q  <= 1'b0;
      host_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      latch_sync_q  <= latch_sync_d;
      clock_sync_q  <= clock_sync_d;
      sr_q          <= sr_d;
      captured_q    <= captured_d;
      bit_count_q   <= bit_count_d;
      wd_count_q    <= wd_count_d;
      snes_data_q   <= snes_data_d;
      frame_tick_q  <= frame_tick_d;
      host_active_q <= host_active_d;
    end
  end

  assign snes_data   = snes_data_q;
  assign frame_tick  = frame_tick_q;
  assign captured    = captured_q;
  assign bit_count   = bit_count_q;
  assign host_active = host_active_q;

endmodule
